hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Groups the ID-stage decode fields, datapath status and the pipeline
//   control/forwarding outputs of the hazard controller into one bundle.
//   master : the datapath side (drives decode fields and status, receives
//            the enables, flushes and forwarding selects)
//   slave  : the hazard controller itself
//   Signals:
//     id_rs, id_rt, id_rd [4:0]  register fields of the instruction in ID
//     id_uses_rt                 ID instruction reads rt
//     id_regwr, id_memrd         ID instruction writes a register / is a load
//     id_regdst                  destination is rd (1) or rt (0)
//     ex_br_taken                branch in EX resolved taken
//     mem_stall                  data memory not ready, freeze pipeline
//     pc_wr, ifid_wr             PC and IF/ID write enables
//     ifid_flush, idex_flush     zero IF/ID, insert bubble into ID/EX
//     fwd_a, fwd_b [1:0]         EX operand selects (00 regfile, 01 EX/MEM,
//                                10 MEM/WB)
//     busy                       controller in INIT or LU
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       id_uses_rt;
  logic       id_regwr;
  logic       id_memrd;
  logic       id_regdst;
  logic       ex_br_taken;
  logic       mem_stall;
  logic       pc_wr;
  logic       ifid_wr;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       busy;

  modport master (
    output id_rs, id_rt, id_rd, id_uses_rt, id_regwr, id_memrd, id_regdst,
           ex_br_taken, mem_stall,
    input  pc_wr, ifid_wr, ifid_flush, idex_flush, fwd_a, fwd_b, busy
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_uses_rt, id_regwr, id_memrd, id_regdst,
           ex_br_taken, mem_stall,
    output pc_wr, ifid_wr, ifid_flush, idex_flush, fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for a classic 5-stage pipeline.
//   Tracks a shadow copy of the EX/MEM/WB destination info, detects
//   load-use hazards (one bubble), flushes on taken branches, freezes on
//   data-memory stalls and produces registered forwarding selects.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     hz     hazard_ctrl_if.slave  decode fields, status and control outputs
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    LU   = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] init_cnt;

  // shadow pipeline
  logic       ex_v, ex_regwr, ex_memrd;
  logic [4:0] ex_dst;
  logic       mem_v, mem_regwr, mem_memrd;
  logic [4:0] mem_dst;
  logic       wb_v, wb_regwr;
  logic [4:0] wb_dst;

  logic [4:0] id_dst;
  logic       load_use;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  logic       pc_wr_c;
  logic       ifid_wr_c;
  logic       ifid_flush_c;
  logic       idex_flush_c;

  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;

  assign id_dst = hz.id_regdst ? hz.id_rd : hz.id_rt;

  // A load in EX whose result the ID instruction needs cannot be
  // forwarded in time; register 0 never counts as a dependency.
  assign load_use = ex_v && ex_memrd && (ex_dst != 5'd0) &&
                    ((ex_dst == hz.id_rs) ||
                     (hz.id_uses_rt && (ex_dst == hz.id_rt)));

  // Forward selects for the instruction about to enter EX: the producer
  // now in EX will sit in EX/MEM, the one now in MEM will sit in MEM/WB.
  // The younger producer wins.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (ex_v && ex_regwr && (ex_dst != 5'd0) && (ex_dst == hz.id_rs))
      fwd_a_next = 2'b01;
    else if (mem_v && mem_regwr && (mem_dst != 5'd0) && (mem_dst == hz.id_rs))
      fwd_a_next = 2'b10;
    if (hz.id_uses_rt) begin
      if (ex_v && ex_regwr && (ex_dst != 5'd0) && (ex_dst == hz.id_rt))
        fwd_b_next = 2'b01;
      else if (mem_v && mem_regwr && (mem_dst != 5'd0) && (mem_dst == hz.id_rt))
        fwd_b_next = 2'b10;
    end
  end

  // Control outputs and next state. Reset forces the INIT-style outputs
  // directly so they hold even while mem_stall is high; mem_stall then
  // freezes everything; a taken branch beats a load-use stall.
  always_comb begin
    pc_wr_c      = 1'b0;
    ifid_wr_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    next_state   = state;
    if (!rst_n) begin
      idex_flush_c = 1'b1;
    end else if (!hz.mem_stall) begin
      case (state)
        INIT: begin
          idex_flush_c = 1'b1;
          if (init_cnt == 2'd1)
            next_state = RUN;
        end
        RUN: begin
          if (hz.ex_br_taken) begin
            pc_wr_c      = 1'b1;
            ifid_wr_c    = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
          end else if (load_use) begin
            idex_flush_c = 1'b1;
            next_state   = LU;
          end else begin
            pc_wr_c   = 1'b1;
            ifid_wr_c = 1'b1;
          end
        end
        LU: begin
          pc_wr_c    = 1'b1;
          ifid_wr_c  = 1'b1;
          next_state = RUN;
          if (hz.ex_br_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
          end
        end
        default: begin
          idex_flush_c = 1'b1;
          next_state   = INIT;
        end
      endcase
    end
  end

  // State, INIT counter, shadow pipeline and forward selects all hold
  // while mem_stall is high. A bubble enters EX whenever ID/EX is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= 2'd0;
      ex_v      <= 1'b0;
      ex_regwr  <= 1'b0;
      ex_memrd  <= 1'b0;
      ex_dst    <= 5'd0;
      mem_v     <= 1'b0;
      mem_regwr <= 1'b0;
      mem_memrd <= 1'b0;
      mem_dst   <= 5'd0;
      wb_v      <= 1'b0;
      wb_regwr  <= 1'b0;
      wb_dst    <= 5'd0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else if (!hz.mem_stall) begin
      state <= next_state;
      if ((state == INIT) && (next_state == INIT))
        init_cnt <= init_cnt + 2'd1;
      else
        init_cnt <= 2'd0;
      wb_v      <= mem_v;
      wb_regwr  <= mem_regwr;
      wb_dst    <= mem_dst;
      mem_v     <= ex_v;
      mem_regwr <= ex_regwr;
      mem_memrd <= ex_memrd;
      mem_dst   <= ex_dst;
      ex_v      <= !idex_flush_c;
      ex_regwr  <= hz.id_regwr;
      ex_memrd  <= hz.id_memrd;
      ex_dst    <= id_dst;
      if (idex_flush_c) begin
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else begin
        fwd_a_q <= fwd_a_next;
        fwd_b_q <= fwd_b_next;
      end
    end
  end

  assign hz.pc_wr      = pc_wr_c;
  assign hz.ifid_wr    = ifid_wr_c;
  assign hz.ifid_flush = ifid_flush_c;
  assign hz.idex_flush = idex_flush_c;
  assign hz.fwd_a      = fwd_a_q;
  assign hz.fwd_b      = fwd_b_q;
  assign hz.busy       = (state == INIT) || (state == LU);

  // The WB stage and the MEM load flag are kept so the shadow pipeline
  // mirrors the real one; nothing downstream of MEM/WB needs them today.
  logic unused_shadow;
  assign unused_shadow = ^{wb_v, wb_regwr, wb_dst, mem_memrd};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl. Control outputs are
//   packed as {pc_wr, ifid_wr, ifid_flush, idex_flush, busy}; forwarding
//   as {fwd_a, fwd_b}. Expected values are hand-computed constants.
module tb_hazard_ctrl;

  localparam logic [7:0] CTL_RESET  = 8'b000_00011;
  localparam logic [7:0] CTL_RUN    = 8'b000_11000;
  localparam logic [7:0] CTL_STALL  = 8'b000_00010;
  localparam logic [7:0] CTL_LU     = 8'b000_11001;
  localparam logic [7:0] CTL_FRZ_LU = 8'b000_00001;
  localparam logic [7:0] CTL_FRZ    = 8'b000_00000;
  localparam logic [7:0] BR_FLUSH   = 8'b0000_1110;
  localparam logic [7:0] FWD_NONE   = 8'h00;
  localparam logic [7:0] FWD_B_EX   = 8'h01;
  localparam logic [7:0] FWD_A_MEM  = 8'h08;
  localparam logic [7:0] FWD_AB_EX  = 8'h05;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  // free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ctl();
    return {3'b000, hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush, hif.busy};
  endfunction

  function automatic logic [7:0] brBits();
    return {4'b0000, hif.pc_wr, hif.ifid_flush, hif.idex_flush, hif.busy};
  endfunction

  function automatic logic [7:0] fwd();
    return {4'b0000, hif.fwd_a, hif.fwd_b};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic uses_rt, input logic regwr, input logic memrd,
                               input logic regdst);
    hif.id_rs      = rs;
    hif.id_rt      = rt;
    hif.id_rd      = rd;
    hif.id_uses_rt = uses_rt;
    hif.id_regwr   = regwr;
    hif.id_memrd   = memrd;
    hif.id_regdst  = regdst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    hif.ex_br_taken = 1'b0;
    hif.mem_stall   = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_ctl", ctl(), CTL_RESET);
    checkOutput("reset_fwd", fwd(), FWD_NONE);

    // release reset: two INIT cycles, then RUN
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("init_cycle1", ctl(), CTL_RESET);
    tick();
    checkOutput("init_cycle2", ctl(), CTL_RESET);
    tick();
    checkOutput("init_to_run", ctl(), CTL_RUN);

    // add $3 into EX, then sub reading rt=3 forwards from EX/MEM
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(5'd4, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("alu_dep_no_stall", ctl(), CTL_RUN);
    tick();
    checkOutput("fwd_b_ex", fwd(), FWD_B_EX);

    // lw $0 with rs=3: add $3 now in MEM gives MEM/WB forward on A
    applyStimulus(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("fwd_a_mem", fwd(), FWD_A_MEM);

    // lw $0 in EX, consumer of $0: neither stall nor forward
    applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("zero_no_stall", ctl(), CTL_RUN);
    tick();
    checkOutput("zero_no_fwd_ex", fwd(), FWD_NONE);

    // lw $5 with rs=0 while lw $0 sits in MEM: still no forward
    applyStimulus(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("zero_no_fwd_mem", fwd(), FWD_NONE);

    // add using rs=5 behind lw $5: one bubble, LU, then forward from MEM/WB
    applyStimulus(5'd5, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("lu_stall", ctl(), CTL_STALL);
    tick();
    checkOutput("lu_state", ctl(), CTL_LU);
    checkOutput("lu_fwd_bubble", fwd(), FWD_NONE);
    tick();
    checkOutput("lu_back_run", ctl(), CTL_RUN);
    checkOutput("lu_fwd_a", fwd(), FWD_A_MEM);

    // lw $9 in EX; rt match only stalls when rt is actually read
    applyStimulus(5'd1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd2, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rt_unused_no_stall", ctl(), CTL_RUN);
    applyStimulus(5'd2, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rt_used_stall", ctl(), CTL_STALL);

    // taken branch overrides the load-use stall, next state RUN
    hif.ex_br_taken = 1'b1;
    #1;
    checkOutput("br_override", brBits(), BR_FLUSH);
    tick();
    hif.ex_br_taken = 1'b0;
    #1;
    checkOutput("br_next_run", ctl(), CTL_RUN);
    checkOutput("br_fwd", fwd(), FWD_NONE);

    // enter LU, then freeze it with mem_stall for 3 cycles
    applyStimulus(5'd1, 5'd10, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("lu2_stall", ctl(), CTL_STALL);
    tick();
    hif.mem_stall = 1'b1;
    #1;
    checkOutput("frozen_lu", ctl(), CTL_FRZ_LU);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("frozen_lu_ctl%0d", i), ctl(), CTL_FRZ_LU);
      checkOutput($sformatf("frozen_lu_fwd%0d", i), fwd(), FWD_NONE);
    end
    hif.mem_stall = 1'b0;
    #1;
    checkOutput("lu_resume", ctl(), CTL_LU);
    tick();
    checkOutput("lu_resume_run", ctl(), CTL_RUN);
    checkOutput("lu_resume_fwd", fwd(), FWD_A_MEM);

    // frozen edge keeps fwd_a (unfrozen it would recompute to 00)
    hif.mem_stall = 1'b1;
    tick();
    checkOutput("frozen_fwd", fwd(), FWD_A_MEM);
    hif.ex_br_taken = 1'b1;
    #1;
    checkOutput("frozen_br", ctl(), CTL_FRZ);
    tick();
    checkOutput("frozen_br_hold", ctl(), CTL_FRZ);
    hif.mem_stall = 1'b0;
    #1;
    checkOutput("br_after_stall", brBits(), BR_FLUSH);
    tick();
    hif.ex_br_taken = 1'b0;

    // two writers of $13 in EX and MEM: EX/MEM wins, rt gated by uses_rt
    applyStimulus(5'd1, 5'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(5'd13, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("fwd_ex_priority", fwd(), FWD_AB_EX);
    applyStimulus(5'd13, 5'd13, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("fwd_mem_rt_gated", fwd(), FWD_A_MEM);

    // reset pulse during LU aborts it; full INIT with no residual bubble
    applyStimulus(5'd1, 5'd12, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd12, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("lu3_state", ctl(), CTL_LU);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_lu_ctl", ctl(), CTL_RESET);
    checkOutput("rst_mid_lu_fwd", fwd(), FWD_NONE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rst_init1", ctl(), CTL_RESET);
    tick();
    checkOutput("rst_init2", ctl(), CTL_RESET);
    tick();
    checkOutput("rst_no_residual", ctl(), CTL_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
